// File: rtl/fb_pkg.sv
// Shared constants and types for the filterbank subband serializer.
package fb_pkg;

  localparam int NUM_BANDS = 16;
  localparam int IN_W      = 37;
  localparam int IN_FRAC   = 32;
  localparam int OUT_W     = 16;
  localparam int SHIFT     = 21;
  localparam int BAND_W    = $clog2(NUM_BANDS);

  typedef logic signed [IN_W-1:0]  sample_in_t;
  typedef logic signed [OUT_W-1:0] sample_out_t;
  typedef logic [BAND_W-1:0]       band_idx_t;

  typedef enum logic {
    IDLE,
    STREAM
  } ser_state_t;

endpackage

// File: rtl/subband_quantizer.sv
// Combinational round-half-up and saturate from a wide fixed-point sample
// to a narrow signed word.
module subband_quantizer #(
  parameter int IN_W  = 37,
  parameter int SHIFT = 21,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  // Width left after the shift; must exceed OUT_W so the saturation test sees the overflow.
  localparam int SH_W = IN_W + 1 - SHIFT;

  localparam logic signed [IN_W:0] HALF =
    {{(IN_W - SHIFT + 1){1'b0}}, 1'b1, {(SHIFT - 1){1'b0}}};
  localparam logic signed [SH_W-1:0] MAX_EXT =
    {{(SH_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [SH_W-1:0] MIN_EXT =
    {{(SH_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};
  localparam logic signed [OUT_W-1:0] MAX_OUT = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic signed [OUT_W-1:0] MIN_OUT = {1'b1, {(OUT_W - 1){1'b0}}};

  logic signed [IN_W:0]   rounded;
  logic signed [SH_W-1:0] shifted;
  logic                   unused_round_bits;

  // One extra bit so adding the half-LSB can never wrap.
  assign rounded = {din[IN_W-1], din} + HALF;
  // Taking the upper bits of a two's-complement value is an arithmetic shift (floor).
  assign shifted = rounded[IN_W:SHIFT];
  // Fraction bits below the rounding point are intentionally discarded.
  assign unused_round_bits = ^rounded[SHIFT-1:0];

  // Clamp the shifted value into the output range.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    dout = shifted[OUT_W-1:0];
    if (shifted > MAX_EXT) begin
      dout = MAX_OUT;
    end else if (shifted < MIN_EXT) begin
      dout = MIN_OUT;
    end
  end

endmodule

// File: rtl/subband_serializer.sv
// Captures a 16-band frame on frame_valid, buffers it in a pending slot,
// and streams quantized bands one per valid/ready beat, band 0 first.
module subband_serializer
  import fb_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        frame_valid,
  input  sample_in_t  filter_in [NUM_BANDS-1:0],
  output logic        out_valid,
  input  logic        out_ready,
  output sample_out_t out_data,
  output band_idx_t   out_band,
  output logic        out_last,
  output logic        overflow,
  output logic [7:0]  overflow_cnt
);

  localparam band_idx_t LAST_BAND = band_idx_t'(NUM_BANDS - 1);

  ser_state_t state, state_next;
  sample_in_t pend [NUM_BANDS-1:0];
  sample_in_t act  [NUM_BANDS-1:0];
  logic       pend_full;
  band_idx_t  band;

  logic accept;
  logic last_accept;
  logic xfer;
  logic capture;
  logic drop;

  assign out_valid = (state == STREAM);
  assign out_band  = band;
  assign out_last  = out_valid && (band == LAST_BAND);

  assign accept      = out_valid && out_ready;
  assign last_accept = accept && out_last;
  // Pending frame moves to the active slot when idle or as the last beat leaves.
  assign xfer        = clk_enable && pend_full && ((state == IDLE) || last_accept);
  // A slot is free if pend is empty or is being emptied on this same edge.
  assign capture     = clk_enable && frame_valid && (!pend_full || xfer);
  assign drop        = clk_enable && frame_valid && pend_full && !xfer;

  subband_quantizer #(
    .IN_W  (IN_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) u_quant (
    .din  (act[band]),
    .dout (out_data)
  );

  // State register; holds while clk_enable is low.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (!reset) begin
      state <= IDLE;
    end else if (clk_enable) begin
      state <= state_next;
    end
  end

  // Next-state decode: start on a transfer, stop after the last beat with nothing pending.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (xfer) state_next = STREAM;
      STREAM:  if (last_accept && !pend_full) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Frame storage, band counter and drop accounting.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pend_full    <= 1'b0;
      band         <= '0;
      overflow     <= 1'b0;
      overflow_cnt <= '0;
      // NOTE: sample storage is cleared on reset so out_data reads zero afterwards.
      for (int i = 0; i < NUM_BANDS; i++) begin
        act[i]  <= '0;
        pend[i] <= '0;
      end
    end else if (clk_enable) begin
      overflow <= drop;
      if (drop && (overflow_cnt != 8'hFF)) begin
        overflow_cnt <= overflow_cnt + 8'd1;
      end

      if (xfer) begin
        act  <= pend;
        band <= '0;
      end else if (accept && !out_last) begin
        band <= band + band_idx_t'(1);
      end

      if (capture) begin
        pend      <= filter_in;
        pend_full <= 1'b1;
      end else if (xfer) begin
        pend_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_subband_serializer.sv
// Self-checking bench: frame-level reference model plus directed scenarios.
module tb_subband_serializer;
  import fb_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        frame_valid;
  sample_in_t  filter_in [NUM_BANDS-1:0];
  logic        out_valid;
  logic        out_ready;
  sample_out_t out_data;
  band_idx_t   out_band;
  logic        out_last;
  logic        overflow;
  logic [7:0]  overflow_cnt;

  subband_serializer dut (
    .clock        (clock),
    .reset        (reset),
    .clk_enable   (clk_enable),
    .frame_valid  (frame_valid),
    .filter_in    (filter_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_band     (out_band),
    .out_last     (out_last),
    .overflow     (overflow),
    .overflow_cnt (overflow_cnt)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference quantizer: floor((x + 2^20) / 2^21), clamped to 16-bit signed.
  function automatic longint q_model(input longint x);
    longint num, q;
    num = x + 64'sd1048576;
    q   = num / 64'sd2097152;
    if ((num % 64'sd2097152 != 0) && (num < 0)) q = q - 1;
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return q;
  endfunction

  typedef struct {
    longint data;
    int     band;
  } beat_t;

  beat_t  exp_q[$];
  logic   exp_ovf = 1'b0;
  int     exp_cnt = 0;
  int     frames_done = 0;
  int     frames_in;
  longint obs_data [NUM_BANDS];
  bit     mon_en = 1'b0;

  // Model: frames queue as 16 expected beats each; a new frame is dropped
  // when two frames are still held after this edge's accepted beat.
  always @(negedge clock) begin
    if (mon_en) begin
      check("overflow", overflow, exp_ovf);
      check("overflow_cnt", overflow_cnt, exp_cnt);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", out_valid, 1'b0);
        end else begin
          check("beat_data", out_data, exp_q[0].data);
          check("beat_band", out_band, exp_q[0].band);
          check("beat_last", out_last, exp_q[0].band == NUM_BANDS - 1);
        end
      end
      if (!reset) begin
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_cnt = 0;
      end else if (clk_enable) begin
        if (out_valid && out_ready && exp_q.size() > 0) begin
          obs_data[out_band] = out_data;
          if (exp_q[0].band == NUM_BANDS - 1) frames_done++;
          void'(exp_q.pop_front());
        end
        frames_in = (exp_q.size() + NUM_BANDS - 1) / NUM_BANDS;
        exp_ovf = 1'b0;
        if (frame_valid) begin
          if (frames_in == 2) begin
            exp_ovf = 1'b1;
            if (exp_cnt < 255) exp_cnt++;
          end else begin
            for (int k = 0; k < NUM_BANDS; k++)
              exp_q.push_back('{data: q_model(longint'(filter_in[k])), band: k});
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_frame();
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
  endtask

  task automatic set_ramp(input int base);
    for (int k = 0; k < NUM_BANDS; k++)
      filter_in[k] = sample_in_t'(longint'(base + k) * 64'sd2097152);
  endtask

  task automatic wait_band(input int b);
    for (int i = 0; i < 64; i++) begin
      if (out_valid && out_band == band_idx_t'(b)) return;
      tick();
    end
    check("wait_band_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_last();
    for (int i = 0; i < 64; i++) begin
      if (out_valid && out_last) return;
      tick();
    end
    check("wait_last_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && !out_valid) return;
      tick();
    end
    check("wait_idle_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    reset = 1'b0; clk_enable = 1'b1; frame_valid = 1'b0; out_ready = 1'b1;
    set_ramp(0);
    repeat (2) @(posedge clock);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_band", out_band, 0);
    check("rst_data", out_data, 0);
    check("rst_ovf", overflow, 0);
    check("rst_cnt", overflow_cnt, 0);
    reset = 1'b1;
    mon_en = 1'b1;

    // Pin the reference quantizer with hand-derived values.
    check("model_half_up", q_model(64'sd1048576), 1);
    check("model_neg_half", q_model(-64'sd1048576), 0);
    check("model_sat_hi", q_model((64'sd1 <<< 36) - 1), 32767);

    // Single frame: 2-cycle latency, 16 beats, out_last on band 15 only.
    set_ramp(0);
    pulse_frame();
    check("lat_edge_n", out_valid, 0);
    tick();
    check("lat_edge_n1", out_valid, 1);
    check("first_band", out_band, 0);
    check("first_data", out_data, 0);
    repeat (15) tick();
    check("band15", out_band, 15);
    check("band15_last", out_last, 1);
    check("band15_data", out_data, 15);
    tick();
    check("back_idle", out_valid, 0);

    // Rounding and saturation corners.
    set_ramp(0);
    filter_in[0] = sample_in_t'(64'sd1048576);
    filter_in[1] = sample_in_t'(-64'sd1048576);
    filter_in[2] = sample_in_t'(-64'sd1048577);
    filter_in[3] = sample_in_t'((64'sd1 <<< 36) - 1);
    filter_in[4] = sample_in_t'(-(64'sd1 <<< 36));
    pulse_frame();
    wait_idle();
    check("q_pos_half", obs_data[0], 1);
    check("q_neg_half", obs_data[1], 0);
    check("q_neg_half_m1", obs_data[2], -1);
    check("q_sat_hi", obs_data[3], 32767);
    check("q_sat_lo", obs_data[4], -32768);

    // Backpressure at band 7 for 5 cycles.
    set_ramp(100);
    pulse_frame();
    wait_band(7);
    out_ready = 1'b0;
    repeat (5) begin
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_band", out_band, 7);
      check("bp_data", out_data, 107);
    end
    out_ready = 1'b1;
    wait_idle();

    // Back-to-back: second frame follows out_last with no gap.
    set_ramp(200);
    pulse_frame();
    repeat (3) tick();
    set_ramp(300);
    pulse_frame();
    wait_last();
    tick();
    check("b2b_valid", out_valid, 1);
    check("b2b_band", out_band, 0);
    check("b2b_data", out_data, 300);
    wait_idle();

    // Overflow: third frame with both slots full and no drain.
    out_ready = 1'b0;
    set_ramp(400);
    pulse_frame();
    repeat (2) tick();
    set_ramp(500);
    pulse_frame();
    set_ramp(600);
    pulse_frame();
    check("ovf_pulse", overflow, 1);
    check("ovf_cnt1", overflow_cnt, 1);
    tick();
    check("ovf_pulse_end", overflow, 0);
    d0 = frames_done;
    out_ready = 1'b1;
    wait_idle();
    check("ovf_frames_out", frames_done - d0, 2);
    check("ovf_f2_tail", obs_data[15], 515);

    // Frame arrives on the same edge as the last-beat handshake with pend full.
    set_ramp(700);
    pulse_frame();
    repeat (2) tick();
    set_ramp(800);
    pulse_frame();
    wait_last();
    set_ramp(900);
    pulse_frame();
    check("sim_no_ovf", overflow, 0);
    check("sim_cnt", overflow_cnt, 1);
    check("sim_valid", out_valid, 1);
    check("sim_band", out_band, 0);
    check("sim_data", out_data, 800);
    wait_idle();
    check("sim_new_frame", obs_data[0], 900);

    // Reset mid-stream at band 9.
    set_ramp(10);
    pulse_frame();
    wait_band(9);
    reset = 1'b0;
    tick();
    check("mrst_valid", out_valid, 0);
    check("mrst_last", out_last, 0);
    check("mrst_band", out_band, 0);
    check("mrst_data", out_data, 0);
    check("mrst_ovf", overflow, 0);
    check("mrst_cnt", overflow_cnt, 0);
    reset = 1'b1;
    tick();

    // Freeze for 3 cycles with a frame_valid pulse inside the window.
    set_ramp(20);
    pulse_frame();
    wait_band(4);
    clk_enable = 1'b0;
    set_ramp(30);
    frame_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      frame_valid = 1'b0;
      check("frz_valid", out_valid, 1);
      check("frz_band", out_band, 4);
      check("frz_data", out_data, 24);
    end
    clk_enable = 1'b1;
    wait_idle();
    check("frz_tail", obs_data[15], 35);
    check("frz_cnt", overflow_cnt, 0);
    repeat (4) tick();
    check("frz_ignored", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
